// File: rtl/serie_paralelo_rx.sv
// serie_paralelo_rx: receive-side serial-to-parallel converter for one PHY lane.
// Rebuilds MSB-first bytes from the bit stream, aligns to the COMMA symbol,
// goes active after BC_REQUIRED aligned commas and then emits one byte per
// 8 bit-clocks with a valid flag and a one-cycle byte strobe.
//
// Handshake: there is no back-pressure. byte_strobe is a one-cycle pulse
// marking the edge on which data_out/valid_out were loaded; the consumer must
// take the byte while byte_strobe is high. valid_out qualifies data_out as a
// data byte (not COMMA), and both hold their value until the next strobe.
module serie_paralelo_rx #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         BC_REQUIRED = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BC_REQ = 4'(BC_REQUIRED);

  // Only the 7 most recent bits are ever read back: together with data_in
  // they form the byte window, so the oldest bit of the shift register is
  // not stored.
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  state_t     r_state;

  logic [7:0] w_win;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_bc_next;

  // Byte completed by the bit sampled on this edge, and boundary decode.
  assign w_win      = {r_sr, data_in};
  assign w_is_comma = (w_win == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_bc_next  = r_bc_cnt + 4'd1;
  assign dbg_state  = r_state;

  // Alignment FSM with shift register, counters and registered outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_bc_cnt    <= '0;
      r_state     <= SEARCH;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      r_sr        <= w_win[6:0];
      byte_strobe <= 1'b0;
      case (r_state)
        SEARCH: begin
          // A comma at any bit offset fixes the byte phase.
          if (w_is_comma) begin
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= 4'd1;
            if (BC_REQ == 4'd1) begin
              r_state <= ACTIVE;
              active  <= 1'b1;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_comma) begin
              r_bc_cnt <= w_bc_next;
              if (w_bc_next == BC_REQ) begin
                r_state <= ACTIVE;
                active  <= 1'b1;
              end
            end else begin
              // Misaligned or broken run: drop back; this edge is not
              // re-tested as a new comma.
              r_state  <= SEARCH;
              r_bc_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          // Sticky: only reset leaves this state; bc_cnt is frozen here.
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            data_out    <= w_win;
            valid_out   <= !w_is_comma;
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          r_state <= SEARCH;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// tb_serie_paralelo_rx: directed bench for serie_paralelo_rx.
// Bits are driven on the falling edge and outputs sampled 1 ns after each
// rising edge. edge_cnt counts rising edges since the last reset release.
module tb_serie_paralelo_rx;

  localparam logic [7:0] COMMA       = 8'hBC;
  localparam int         BC_REQUIRED = 4;

  // ---------------- clock / reset ----------------
  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  logic data_in = 1'b0;

  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;
  logic [1:0] dbg_state;

  always #5 clk_32f = ~clk_32f;

  serie_paralelo_rx #(
    .COMMA       (COMMA),
    .BC_REQUIRED (BC_REQUIRED)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .byte_strobe (byte_strobe),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt;
  int act_edge;
  int strobe_edge;
  int last_strobe;
  int n_strobes;
  logic       have_held;
  logic [8:0] held;
  logic [8:0] exp_q[$];   // {valid, byte} expected at each strobe

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic clear_track();
    edge_cnt    = 0;
    act_edge    = 0;
    strobe_edge = 0;
    last_strobe = 0;
    n_strobes   = 0;
    have_held   = 1'b0;
    held        = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    logic [8:0] e;
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
    edge_cnt++;
    if (active && act_edge == 0) act_edge = edge_cnt;
    if (byte_strobe) begin
      n_strobes++;
      if (strobe_edge == 0) strobe_edge = edge_cnt;
      if (last_strobe != 0) check_eq("strobe_period", edge_cnt - last_strobe, 8);
      last_strobe = edge_cnt;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
        check_eq("valid_out", {31'd0, valid_out}, {31'd0, e[8]});
        held      = e;
        have_held = 1'b1;
      end else begin
        check_eq("spurious_strobe", {31'd0, byte_strobe}, 32'd0);
      end
    end else if (have_held) begin
      check_eq("hold", {23'd0, valid_out, data_out}, {23'd0, held});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(COMMA);
  endtask

  // Pulse reset and release it just after a rising edge so the next edge is edge 1.
  task automatic do_reset();
    @(negedge clk_32f);
    data_in = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    clear_track();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_track();

    // Reset held low with random serial activity: all outputs stay 0.
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      check_eq("rst_outputs", {21'd0, data_out, valid_out, active, byte_strobe},
               32'd0);
    end
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk_32f);
    reset = 1'b1;
    clear_track();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    check_eq("idle_no_active", act_edge, 0);

    // Alignment at a 3-bit offset: active after edge 35, first strobe at 43.
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_commas(4);
    check_eq("offset_act_edge", act_edge, 35);
    check_eq("offset_no_strobe_yet", strobe_edge, 0);
    exp_q.push_back({1'b1, 8'h00});
    send_byte(8'h00);
    check_eq("offset_first_strobe", strobe_edge, 43);

    // Broken comma run: 3 commas, 0x55, then 4 commas -> active after edge 64.
    do_reset();
    send_commas(3);
    send_byte(8'h55);
    check_eq("broken_still_idle", act_edge, 0);
    send_commas(4);
    check_eq("broken_act_edge", act_edge, 64);
    check_eq("broken_dbg_state", {30'd0, dbg_state}, 32'd2);

    // Data delivery on the active lane.
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h3C});
    exp_q.push_back({1'b0, 8'hBC});
    exp_q.push_back({1'b1, 8'h00});
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'hBC);
    send_byte(8'h00);
    check_eq("data_strobes", n_strobes, 4);
    check_eq("data_q_drained", exp_q.size(), 0);
    check_eq("data_first_strobe", strobe_edge, 72);

    // Reset mid-byte while active: outputs clear without a clock edge.
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C);
    check_eq("pre_rst_data", {24'd0, data_out}, 32'h3C);
    check_eq("pre_rst_active", {31'd0, active}, 32'd1);
    for (int i = 7; i >= 4; i--) send_bit(8'hA5 >> i);
    reset = 1'b0;
    #1;
    check_eq("async_rst_outputs", {21'd0, data_out, valid_out, active, byte_strobe},
             32'd0);
    check_eq("async_rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    clear_track();
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h3C);
    check_eq("post_rst_data_idle", act_edge, 0);
    send_commas(4);
    check_eq("post_rst_act_edge", act_edge, 56);
    check_eq("post_rst_active", {31'd0, active}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serie_paralelo_rx.md
# serie_paralelo_rx

Receive-side serial-to-parallel converter for one PHY lane. It runs on the bit clock and reconstructs bytes from the MSB-first serial stream produced by the transmit-side parallel-to-serial stage. It aligns to the 0xBC comma (idle) symbol and declares the lane active after a run of aligned commas. Once active, it delivers bytes with a valid flag to the receive-side demux feeding out0_rx..out3_rx.

## Interface
- COMMA, 8'hBC, idle/alignment symbol
- BC_REQUIRED, 4, consecutive aligned commas needed to go active (1..15)
- clk_32f  input  1  bit clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- data_in  input  1  serial bit, MSB first, one bit per clk_32f cycle
- data_out  output  8  last received byte, held between byte boundaries
- valid_out  output  1  1 when data_out is a data byte (not COMMA); only while active
- active  output  1  lane aligned and active; sticky until reset
- byte_strobe  output  1  one-cycle pulse on each byte boundary while active

## Operation
- Shift register sr[7:0] updates every cycle: sr <= {sr[6:0], data_in}. Window w = {sr[6:0], data_in} is the byte completed by the bit sampled this edge.
- bit_cnt (3 bits): byte-position counter. bc_cnt (4 bits): count of aligned commas.
- State SEARCH, which is the reset state:
  - Any edge with w == COMMA gives bit_cnt <= 0, bc_cnt <= 1, and a move to ALIGN. If BC_REQUIRED == 1, the move is straight to ACTIVE instead.
  - Otherwise, hold.
- State ALIGN:
  - bit_cnt increments every cycle and wraps 7 -> 0. A boundary is an edge where bit_cnt == 7.
  - At a boundary with w == COMMA, bc_cnt increments. When the incremented value equals BC_REQUIRED, move to ACTIVE.
  - At a boundary with w != COMMA, move to SEARCH and set bc_cnt <= 0. This edge is not itself re-tested as a comma.
- State ACTIVE:
  - bit_cnt keeps wrapping.
  - At each boundary: data_out <= w, valid_out <= (w != COMMA), byte_strobe <= 1.
  - byte_strobe is 0 on all other edges.
  - No de-activation path exists; only reset leaves ACTIVE.
- active is registered and equals (state == ACTIVE).
- All counter arithmetic is modulo its width. bc_cnt saturates and is unused once ACTIVE.

## Timing
- Reset values:
  - data_out = 8'h00, valid_out = 0, active = 0, byte_strobe = 0.
  - sr = 0, bit_cnt = 0, bc_cnt = 0, state = SEARCH.
- Reset is asynchronous and takes effect mid-byte and in any state. After release, alignment restarts from SEARCH and BC_REQUIRED new commas are needed.
- Edge k is the edge on which the last bit (LSB) of the BC_REQUIRED-th comma is sampled:
  - active rises after edge k.
  - No byte_strobe occurs on edge k.
- Data latency:
  - The first data byte's LSB is sampled on edge k+8.
  - data_out, valid_out and byte_strobe update on that same edge.
  - In general, the outputs change one edge after the data LSB is on data_in.
- Byte boundaries fall exactly every 8 cycles while active; byte_strobe is high for 1 of every 8 cycles.
- data_out and valid_out are held constant between boundaries.
- A comma appearing in SEARCH at any bit offset is accepted. Spurious matches straddling two data bytes are rejected by the boundary checks in ALIGN.

## Test plan
- Reset check: hold reset=0 while toggling data_in randomly. Required: all outputs stay 0. After release, active stays 0 until commas are sent.
- Alignment at an offset: send 3 zero bits, then 4 x 0xBC (BC_REQUIRED=4). Required: active rises after edge 35, counting the first post-reset edge as 1. No byte_strobe occurs before edge 43.
- Broken comma run: send 3 x 0xBC, then 0x55, then 4 x 0xBC. Required: active stays 0 through the 0x55 and rises only after the last bit of the 4th comma of the second run.
- Data delivery: once active, send 0xA5, 0x3C, 0xBC, 0x00. Required:
  - data_out goes A5, 3C, BC, 00 with valid_out 1, 1, 0, 1.
  - byte_strobe pulses every 8 cycles.
  - Each value is held for 8 cycles.
- Reset mid-operation: assert reset for 2 cycles at bit 4 of a data byte while active. Required: outputs drop to 0 immediately without waiting for a clock. After release, send data only: active stays 0. Then send 4 x 0xBC: active rises.
